boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream of the core and of the DDR2 data-memory path: consumes the raw UART receive byte stream after the host handshake and loads the program image.
- Assembles little-endian 32-bit words, parses a 3-word header, writes instruction words to instruction memory and data words to data memory through a req/done handshake.
- Raises `program_fin` with the entry PC so the top level can release the core.

Parameters:
- IMEM_DEPTH, 32768: instruction-memory capacity in words; larger images are flagged as errors.
- DATA_BASE, 32'h0000_0000: byte address of the first data word.
- ADDR_W, 32: width of address outputs.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms the loader (ignored unless IDLE)
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  received byte
- rx_ready  out  1  byte consumed on a cycle where rx_valid && rx_ready
- imem_we  out  1  one-cycle instruction write strobe
- imem_addr  out  ADDR_W  byte address, 4*index
- imem_wdata  out  32  instruction word
- dmem_req  out  1  data write request, held until dmem_done
- dmem_addr  out  ADDR_W  DATA_BASE + 4*k
- dmem_wdata  out  32  data word
- dmem_done  in  1  memory write complete (sampled only while dmem_req=1)
- entry_pc  out  32  header word 0
- program_fin  out  1  level; image fully loaded
- load_err  out  1  sticky error (oversize image or checksum mismatch)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-load aborts to IDLE and discards partial words; no memory request remains asserted.
- Byte assembler:
  - 2-bit byte index; byte i goes to word[8i+7:8i].
  - A word is complete on the cycle the 4th byte is consumed.
  - Running XOR checksum covers all bytes except the checksum byte.
- Image format, in order:
  - entry PC, instruction count N, data count M (all words);
  - N instruction words;
  - M data words;
  - 1 checksum byte.
- States:
  - IDLE: rx_ready=0. start -> HDR, clearing counters, checksum and load_err.
  - HDR: rx_ready=1. Word 0 -> entry_pc; word 1 -> N; word 2 -> M. After word 2: N>0 -> IMEM; else M>0 -> DCOL; else -> CSUM.
  - IMEM: rx_ready=1. Each completed word drives imem_we=1 for exactly one cycle, with imem_addr=4*i and imem_wdata=word, registered 1 cycle after the last byte. If i >= IMEM_DEPTH, imem_we is suppressed, load_err is set, and the word is still consumed. After word N-1: M>0 -> DCOL, else -> CSUM.
  - DCOL: rx_ready=1. A completed word registers into dmem_wdata and dmem_addr = DATA_BASE + 4*k, then -> DWAIT.
  - DWAIT: rx_ready=0 (backpressure; source holds its byte) and dmem_req=1. When dmem_done=1: dmem_req=0 next cycle, k++; k==M -> CSUM, else -> DCOL.
  - CSUM: rx_ready=1. Consume 1 byte; mismatch vs running XOR sets load_err. -> DONE.
  - DONE: program_fin=1, rx_ready=0; holds until reset. start is ignored.
- dmem_done is ignored while dmem_req=0. dmem_addr and dmem_wdata are stable for the whole request.
- N and M are 32-bit; counters wrap-free (compare for equality). entry_pc is valid once program_fin=1.
- start while not IDLE: ignored.

Decomposition:
- Shared package (`loader_pkg`) holds:
  - state encoding constants;
  - header word indices (HDR_PC=0, HDR_N=1, HDR_M=2);
  - DATA_BASE default.
- One natural sub-module: `byte_word_assembler`, covering byte index, shift register, word-complete pulse and XOR checksum.

Test Plan:
- N=2, M=0, PC=0x100, instructions 0x11223344 and 0x55667788, correct checksum:
  - imem_we pulses at addr 0 and 4 with those words;
  - program_fin=1, entry_pc=0x100, load_err=0.
- N=0, M=2, data 0xDEADBEEF and 0x01020304, dmem_done delayed 5 cycles each:
  - dmem_req held high with addr DATA_BASE then DATA_BASE+4;
  - rx_ready=0 throughout DWAIT; bytes arriving meanwhile are not lost.
- N=0, M=0: after the header and checksum byte, program_fin=1 with no imem_we or dmem_req activity.
- Wrong checksum byte: load_err=1, program_fin=1.
- Parameter IMEM_DEPTH=2 with N=3: exactly 2 imem_we pulses, load_err=1, and the following data words are still loaded correctly.
- rstn asserted mid-IMEM after 2 bytes of a word:
  - outputs return to 0 immediately;
  - a new start followed by a full image loads correctly, with no stale bytes in the assembled words.

Source files
------------

// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot loader: FSM state
//               encoding, header word indices and parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

   // Loader FSM states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_IMEM  = 3'd2,
      ST_DCOL  = 3'd3,
      ST_DWAIT = 3'd4,
      ST_CSUM  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Position of each header word within the 3-word header
   localparam logic [1:0] HDR_PC = 2'd0;
   localparam logic [1:0] HDR_N  = 2'd1;
   localparam logic [1:0] HDR_M  = 2'd2;

   // Bytes per assembled word (little-endian)
   localparam int BYTES_PER_WORD = 4;

   // Parameter defaults for the top level
   localparam logic [31:0] DATA_BASE_DEFAULT  = 32'h0000_0000;
   localparam int          IMEM_DEPTH_DEFAULT = 32768;

endpackage : loader_pkg

`default_nettype wire

// File: rtl/byte_word_assembler.sv
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs a little-endian byte stream into 32-bit words and keeps
//               a running XOR checksum of every byte it accepts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr,        // synchronous clear of index, partial word and checksum
   input  logic        byte_en,    // a byte is consumed this cycle
   input  logic [7:0]  byte_data,
   output logic [31:0] word,       // valid while word_done is high
   output logic        word_done,  // high on the cycle the last byte of a word is consumed
   output logic [7:0]  csum        // XOR of every byte accepted since the last clear
);

   localparam logic [1:0] c_last_idx = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  r_idx;
   logic [23:0] r_shift;
   logic [7:0]  r_csum;

   // The first three bytes shift in from the top so that after three bytes
   // r_shift holds {b2,b1,b0}; the fourth byte is concatenated on top
   // combinationally, making the word available in the same cycle.
   assign word      = {byte_data, r_shift};
   assign word_done = byte_en && (r_idx == c_last_idx);
   assign csum      = r_csum;

   // Byte index, partial-word shift register and running checksum
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
         r_csum  <= 8'd0;
      end else if (clr) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
         r_csum  <= 8'd0;
      end else if (byte_en) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= {byte_data, r_shift[23:8]};
         r_csum  <= r_csum ^ byte_data;
      end
   end

endmodule : byte_word_assembler

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module      : boot_loader
// Description : Loads a program image from the UART byte stream: parses the
//               3-word header, writes instruction words to instruction memory,
//               data words to data memory through a req/done handshake, checks
//               the trailing XOR checksum and reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader
   import loader_pkg::*;
#(
   parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
   parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
   parameter int          ADDR_W     = 32
)
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              dmem_req,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_done,
   output logic [31:0]       entry_pc,
   output logic              program_fin,
   output logic              load_err
);

   localparam logic [31:0] c_imem_depth = 32'(IMEM_DEPTH);

   state_t      r_state;
   logic [1:0]  r_hdr_idx;   // which header word is being assembled
   logic [31:0] r_n;         // instruction word count from the header
   logic [31:0] r_m;         // data word count from the header
   logic [31:0] r_i;         // instruction words consumed so far
   logic [31:0] r_k;         // data words written so far

   logic        w_take;      // a byte is consumed this cycle
   logic        w_asm_en;    // consumed byte belongs to a word (not the checksum byte)
   logic        w_asm_clr;
   logic [31:0] w_word;
   logic        w_word_done;
   logic [7:0]  w_csum;
   logic [31:0] w_i_byte;    // byte offset of the current instruction word
   logic [31:0] w_k_byte;    // byte offset of the current data word

   assign w_take    = rx_valid && rx_ready;
   assign w_asm_en  = w_take && ((r_state == ST_HDR) ||
                                 (r_state == ST_IMEM) ||
                                 (r_state == ST_DCOL));
   // Held clear while idle so every load starts with an empty word and a
   // zero checksum, regardless of what a previous (possibly aborted) load left.
   assign w_asm_clr = (r_state == ST_IDLE);
   assign w_i_byte  = {r_i[29:0], 2'b00};
   assign w_k_byte  = {r_k[29:0], 2'b00};

   byte_word_assembler u_asm (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (w_asm_clr),
      .byte_en   (w_asm_en),
      .byte_data (rx_data),
      .word      (w_word),
      .word_done (w_word_done),
      .csum      (w_csum)
   );

   // Loader FSM; every output is a register updated alongside the state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_hdr_idx   <= 2'd0;
         r_n         <= 32'd0;
         r_m         <= 32'd0;
         r_i         <= 32'd0;
         r_k         <= 32'd0;
         rx_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= 32'd0;
         dmem_req    <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= 32'd0;
         entry_pc    <= 32'd0;
         program_fin <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         // Instruction write strobe is a single-cycle pulse
         imem_we <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_HDR;
                  rx_ready  <= 1'b1;
                  r_hdr_idx <= 2'd0;
                  r_n       <= 32'd0;
                  r_m       <= 32'd0;
                  r_i       <= 32'd0;
                  r_k       <= 32'd0;
                  entry_pc  <= 32'd0;
                  load_err  <= 1'b0;
               end
            end

            ST_HDR: begin
               if (w_word_done) begin
                  r_hdr_idx <= r_hdr_idx + 2'd1;
                  case (r_hdr_idx)
                     HDR_PC: entry_pc <= w_word;
                     HDR_N:  r_n      <= w_word;
                     default: begin
                        // Last header word: the data count is still on the
                        // assembler output, so branch on it directly.
                        r_m <= w_word;
                        if (r_n != 32'd0) begin
                           r_state <= ST_IMEM;
                        end else if (w_word != 32'd0) begin
                           r_state <= ST_DCOL;
                        end else begin
                           r_state <= ST_CSUM;
                        end
                     end
                  endcase
               end
            end

            ST_IMEM: begin
               if (w_word_done) begin
                  // Words beyond the memory are still consumed so the stream
                  // stays aligned for the data section and checksum.
                  if (r_i < c_imem_depth) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= ADDR_W'(w_i_byte);
                     imem_wdata <= w_word;
                  end else begin
                     load_err <= 1'b1;
                  end
                  r_i <= r_i + 32'd1;
                  if (r_i == (r_n - 32'd1)) begin
                     r_state <= (r_m != 32'd0) ? ST_DCOL : ST_CSUM;
                  end
               end
            end

            ST_DCOL: begin
               if (w_word_done) begin
                  dmem_wdata <= w_word;
                  dmem_addr  <= ADDR_W'(DATA_BASE) + ADDR_W'(w_k_byte);
                  dmem_req   <= 1'b1;
                  rx_ready   <= 1'b0;
                  r_state    <= ST_DWAIT;
               end
            end

            ST_DWAIT: begin
               // Source is back-pressured here; address and data stay frozen
               if (dmem_done) begin
                  dmem_req <= 1'b0;
                  rx_ready <= 1'b1;
                  r_k      <= r_k + 32'd1;
                  r_state  <= ((r_k + 32'd1) == r_m) ? ST_CSUM : ST_DCOL;
               end
            end

            ST_CSUM: begin
               if (w_take) begin
                  if (rx_data != w_csum) begin
                     load_err <= 1'b1;
                  end
                  rx_ready    <= 1'b0;
                  program_fin <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end

            ST_DONE: begin
               // Terminal until reset; start is deliberately not decoded here
               rx_ready    <= 1'b0;
               program_fin <= 1'b1;
            end

            default: begin
               r_state  <= ST_IDLE;
               rx_ready <= 1'b0;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule : boot_loader

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module      : tb_boot_loader
// Description : Directed, table-driven bench for boot_loader. Each table row
//               describes an image and the memory traffic and status it must
//               produce; extra hand-written sequences cover reset mid-load and
//               start pulses after completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

   localparam int          c_depth = 2;
   localparam logic [31:0] c_base  = 32'h8000_0000;
   localparam int          c_dly   = 5;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_done;
   logic [31:0] entry_pc;
   logic        program_fin;
   logic        load_err;

   boot_loader #(
      .IMEM_DEPTH (c_depth),
      .DATA_BASE  (c_base),
      .ADDR_W     (32)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .dmem_req    (dmem_req),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_done   (dmem_done),
      .entry_pc    (entry_pc),
      .program_fin (program_fin),
      .load_err    (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One image and the outcome it must produce
   typedef struct {
      logic [31:0]       pc;
      logic [31:0]       n;
      logic [31:0]       m;
      logic [3:0][31:0]  w;          // instruction words then data words
      bit                bad_csum;
      int                exp_imem;   // imem_we pulses expected
      int                exp_dmem;   // dmem requests expected
      logic              exp_err;
   } vec_t;

   vec_t vecs [6];

   int n_vec  = 0;
   int n_fail = 0;

   logic [31:0] ia_q[$];
   logic [31:0] id_q[$];
   logic [31:0] da_q[$];
   logic [31:0] dd_q[$];
   int          stab_err = 0;
   int          rr_err   = 0;
   logic        prev_req = 1'b0;
   logic [31:0] held_a, held_d;
   int          dcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory traffic monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (imem_we) begin
         ia_q.push_back(imem_addr);
         id_q.push_back(imem_wdata);
      end
      if (dmem_req) begin
         if (!prev_req) begin
            da_q.push_back(dmem_addr);
            dd_q.push_back(dmem_wdata);
            held_a = dmem_addr;
            held_d = dmem_wdata;
         end else if (dmem_addr !== held_a || dmem_wdata !== held_d) begin
            stab_err++;
         end
         if (rx_ready) rr_err++;
      end
      prev_req = dmem_req;
   end

   // Data memory model: completes each request c_dly cycles after it rises
   always @(negedge clk) begin
      if (dmem_req && !dmem_done) begin
         if (dcnt == c_dly - 1) dmem_done = 1'b1;
         else dcnt++;
      end else begin
         dmem_done = 1'b0;
         dcnt      = 0;
      end
   end

   // Present a byte (from a falling edge) and hold it until consumed
   task automatic send_byte(input logic [7:0] b);
      int guard;
      rx_valid = 1'b1;
      rx_data  = b;
      guard    = 0;
      while (!rx_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] wd, inout logic [7:0] cs);
      for (int b = 0; b < 4; b++) begin
         send_byte(wd[8*b +: 8]);
         cs = cs ^ wd[8*b +: 8];
      end
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
      stab_err = 0;
      rr_err   = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Stream one table image through the DUT and check everything it did
   task automatic run_vec(input int v);
      logic [7:0] cs;
      int         guard;
      vec_t       t;
      t  = vecs[v];
      cs = 8'd0;
      pulse_start();
      send_word(t.pc, cs);
      send_word(t.n, cs);
      send_word(t.m, cs);
      for (int i = 0; i < int'(t.n + t.m); i++) send_word(t.w[i], cs);
      send_byte(t.bad_csum ? ~cs : cs);
      rx_valid = 1'b0;
      guard = 0;
      while (!program_fin && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d program_fin", v), {31'd0, program_fin}, 32'd1);
      chk($sformatf("v%0d entry_pc", v), entry_pc, t.pc);
      chk($sformatf("v%0d load_err", v), {31'd0, load_err}, {31'd0, t.exp_err});
      chk($sformatf("v%0d rx_ready_done", v), {31'd0, rx_ready}, 32'd0);
      chk($sformatf("v%0d imem_cnt", v), ia_q.size(), t.exp_imem);
      for (int i = 0; i < t.exp_imem; i++) begin
         chk($sformatf("v%0d imem_addr%0d", v, i), (i < ia_q.size()) ? ia_q[i] : 32'hxxxx_xxxx, 32'(4 * i));
         chk($sformatf("v%0d imem_data%0d", v, i), (i < id_q.size()) ? id_q[i] : 32'hxxxx_xxxx, t.w[i]);
      end
      chk($sformatf("v%0d dmem_cnt", v), da_q.size(), t.exp_dmem);
      for (int k = 0; k < t.exp_dmem; k++) begin
         chk($sformatf("v%0d dmem_addr%0d", v, k), (k < da_q.size()) ? da_q[k] : 32'hxxxx_xxxx, c_base + 32'(4 * k));
         chk($sformatf("v%0d dmem_data%0d", v, k), (k < dd_q.size()) ? dd_q[k] : 32'hxxxx_xxxx, t.w[int'(t.n) + k]);
      end
      chk($sformatf("v%0d dmem_stable", v), stab_err, 0);
      chk($sformatf("v%0d rx_ready_in_dwait", v), rr_err, 0);
   endtask

   initial begin
      vecs[0] = '{pc: 32'h100, n: 2, m: 0, w: {32'h0, 32'h0, 32'h55667788, 32'h11223344},
                  bad_csum: 0, exp_imem: 2, exp_dmem: 0, exp_err: 1'b0};
      vecs[1] = '{pc: 32'h200, n: 0, m: 2, w: {32'h0, 32'h0, 32'h01020304, 32'hDEADBEEF},
                  bad_csum: 0, exp_imem: 0, exp_dmem: 2, exp_err: 1'b0};
      vecs[2] = '{pc: 32'h300, n: 0, m: 0, w: '0,
                  bad_csum: 0, exp_imem: 0, exp_dmem: 0, exp_err: 1'b0};
      vecs[3] = '{pc: 32'h100, n: 2, m: 0, w: {32'h0, 32'h0, 32'h55667788, 32'h11223344},
                  bad_csum: 1, exp_imem: 2, exp_dmem: 0, exp_err: 1'b1};
      vecs[4] = '{pc: 32'h400, n: 3, m: 1, w: {32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3},
                  bad_csum: 0, exp_imem: 2, exp_dmem: 1, exp_err: 1'b1};
      vecs[5] = '{pc: 32'h500, n: 1, m: 1, w: {32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D},
                  bad_csum: 0, exp_imem: 1, exp_dmem: 1, exp_err: 1'b0};

      dmem_done = 1'b0;
      do_reset();

      // Reset state
      chk("rst rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst program_fin", {31'd0, program_fin}, 32'd0);
      chk("rst load_err", {31'd0, load_err}, 32'd0);
      chk("rst entry_pc", entry_pc, 32'd0);

      // Table-driven images, each from a fresh reset
      for (int v = 0; v < 6; v++) begin
         do_reset();
         run_vec(v);
      end

      // A start pulse after completion must not re-arm the loader
      pulse_start();
      repeat (2) @(negedge clk);
      chk("start_in_done program_fin", {31'd0, program_fin}, 32'd1);
      chk("start_in_done rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("start_in_done entry_pc", entry_pc, 32'h500);

      // Reset in the middle of an instruction word, then a clean reload
      do_reset();
      begin
         logic [7:0] cs;
         cs = 8'd0;
         pulse_start();
         send_word(32'h0000_0100, cs);
         send_word(32'd2, cs);
         send_word(32'd0, cs);
         send_byte(8'h44);
         send_byte(8'h33);
         rx_valid = 1'b0;
         #2 rstn = 1'b0;
         #1;
         chk("midrst rx_ready", {31'd0, rx_ready}, 32'd0);
         chk("midrst entry_pc", entry_pc, 32'd0);
         chk("midrst program_fin", {31'd0, program_fin}, 32'd0);
         chk("midrst imem_we", {31'd0, imem_we}, 32'd0);
         chk("midrst dmem_req", {31'd0, dmem_req}, 32'd0);
         @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
         run_vec(0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_boot_loader

`default_nettype wire
